// File: rtl/nco_pkg.sv
// Shared widths and FSM state type for the NCO phase bank.
//   OWNER_W      - width of the channel/owner index
//   PHASE_W      - width of phase, accumulator, tuning word and offset
//   MAX_CHANNELS - storage depth; the active channel count is a top-level parameter
package nco_pkg;

  localparam int unsigned OWNER_W      = 4;
  localparam int unsigned PHASE_W      = 16;
  localparam int unsigned MAX_CHANNELS = 16;

  typedef enum logic {
    StIdle,
    StSweep
  } state_e;

endpackage

// File: rtl/nco_reg_file.sv
// Per-channel storage for the NCO phase bank: tuning words, phase accumulators and,
// when NCO_PHASE_OFFSET_EN is defined, phase offsets.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   rd_idx_i           - shared read index; also the accumulator write address
//   ftw_o/acc_o/off_o  - tuning word, accumulator and offset of channel rd_idx_i
//   acc_we_i           - write acc_wdata_i into the accumulator of channel rd_idx_i
//   acc_wdata_i        - accumulator write data
//   acc_clr_i          - zero every accumulator (tuning words and offsets untouched)
//   cfg_we_i           - write cfg_data_i as the tuning word of channel cfg_addr_i
//   cfg_off_we_i       - write cfg_data_i as the offset of channel cfg_addr_i
//   cfg_addr_i         - config target channel; addresses >= Channels are ignored
//   cfg_data_i         - config write data
// Macro NCO_PHASE_OFFSET_EN builds the offset array; otherwise off_o is zero.
module nco_reg_file
  import nco_pkg::*;
#(
  parameter int unsigned Channels = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [OWNER_W-1:0] rd_idx_i,
  output logic [PHASE_W-1:0] ftw_o,
  output logic [PHASE_W-1:0] acc_o,
  output logic [PHASE_W-1:0] off_o,
  input  logic               acc_we_i,
  input  logic [PHASE_W-1:0] acc_wdata_i,
  input  logic               acc_clr_i,
  input  logic               cfg_we_i,
  input  logic               cfg_off_we_i,
  input  logic [OWNER_W-1:0] cfg_addr_i,
  input  logic [PHASE_W-1:0] cfg_data_i
);

  localparam logic [OWNER_W:0] ChanCnt = (OWNER_W + 1)'(Channels);

  logic               cfg_hit;
  logic [PHASE_W-1:0] ftw_q [MAX_CHANNELS];
  logic [PHASE_W-1:0] acc_q [MAX_CHANNELS];

  assign cfg_hit = ({1'b0, cfg_addr_i} < ChanCnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_CHANNELS; i++) ftw_q[i] <= '0;
    end else if (cfg_we_i && cfg_hit) begin
      ftw_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_CHANNELS; i++) acc_q[i] <= '0;
    end else if (acc_clr_i) begin
      for (int i = 0; i < MAX_CHANNELS; i++) acc_q[i] <= '0;
    end else if (acc_we_i) begin
      acc_q[rd_idx_i] <= acc_wdata_i;
    end
  end

  // Reads see pre-write contents, so a same-cycle config write cannot affect this update.
  assign ftw_o = ftw_q[rd_idx_i];
  assign acc_o = acc_q[rd_idx_i];

`ifdef NCO_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] off_q [MAX_CHANNELS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_CHANNELS; i++) off_q[i] <= '0;
    end else if (cfg_off_we_i && cfg_hit) begin
      off_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  assign off_o = off_q[rd_idx_i];
`else
  logic unused_off_we;
  assign unused_off_we = cfg_off_we_i;
  assign off_o         = '0;
`endif

endmodule

// File: rtl/nco_phase_bank.sv
// Multi-channel NCO front end: on each tick, sweeps channels 0..CHANNELS-1 one per clock,
// emitting (owner, phase) and advancing each accumulator by its tuning word.
// Ports:
//   clk_i, rst_ni         - clock, asynchronous active-low reset
//   tick_i                - sample strobe; starts (or queues) a sweep
//   cfg_we_i              - write cfg_ftw_i as tuning word of channel cfg_addr_i
//   cfg_off_we_i          - write cfg_ftw_i as phase offset of channel cfg_addr_i
//   cfg_addr_i            - config target channel
//   cfg_ftw_i             - config data
//   cfg_sync_i            - zero accumulators, abort sweep, clear pending/overrun
//   out_valid_o           - owner_o/phase_o valid this cycle
//   owner_o, phase_o      - channel index and phase for the sine pipeline
//   busy_o                - sweep output in flight or a sweep pending
//   overrun_o             - sticky: a tick was dropped
// Macro NCO_PHASE_OFFSET_EN adds a per-channel offset to the emitted phase.
module nco_phase_bank
  import nco_pkg::*;
#(
  parameter int unsigned CHANNELS = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               cfg_we_i,
  input  logic               cfg_off_we_i,
  input  logic [OWNER_W-1:0] cfg_addr_i,
  input  logic [PHASE_W-1:0] cfg_ftw_i,
  input  logic               cfg_sync_i,
  output logic               out_valid_o,
  output logic [OWNER_W-1:0] owner_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               busy_o,
  output logic               overrun_o
);

  localparam logic [OWNER_W-1:0] LastIdx = OWNER_W'(CHANNELS - 1);

  state_e             state_q, state_d;
  logic [OWNER_W-1:0] idx_q, idx_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               valid_q, valid_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               busy_q, busy_d;

  logic               emit;
  logic               acc_we;
  logic               acc_clr;
  logic [PHASE_W-1:0] ftw_rd, acc_rd, off_rd;

  nco_reg_file #(
    .Channels (CHANNELS)
  ) u_reg_file (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_idx_i     (idx_q),
    .ftw_o        (ftw_rd),
    .acc_o        (acc_rd),
    .off_o        (off_rd),
    .acc_we_i     (acc_we),
    .acc_wdata_i  (acc_rd + ftw_rd),
    .acc_clr_i    (acc_clr),
    .cfg_we_i     (cfg_we_i),
    .cfg_off_we_i (cfg_off_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_ftw_i)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    valid_d   = 1'b0;
    owner_d   = owner_q;
    phase_d   = phase_q;
    emit      = 1'b0;
    acc_we    = 1'b0;
    acc_clr   = 1'b0;

    if (cfg_sync_i) begin
      // A coincident tick starts a fresh sweep next cycle from the zeroed accumulators.
      acc_clr   = 1'b1;
      pending_d = 1'b0;
      overrun_d = 1'b0;
      idx_d     = '0;
      state_d   = tick_i ? StSweep : StIdle;
    end else begin
      unique case (state_q)
        // Channel 0 is emitted in the tick cycle itself so output appears one cycle later.
        StIdle:  emit = tick_i;
        StSweep: begin
          emit = 1'b1;
          if (tick_i) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
          end
        end
        default: ;
      endcase

      if (emit) begin
        valid_d = 1'b1;
        owner_d = idx_q;
        phase_d = acc_rd + off_rd;
        acc_we  = 1'b1;
        if (idx_q == LastIdx) begin
          idx_d = '0;
          // pending_d includes a tick arriving in this final cycle.
          if (pending_d) begin
            pending_d = 1'b0;
            state_d   = StSweep;
          end else begin
            state_d = StIdle;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StSweep;
        end
      end
    end

    // Aligned with the output stage so busy covers every valid cycle of a sweep.
    busy_d = valid_d | pending_d | (state_d == StSweep);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      owner_q   <= '0;
      phase_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      owner_q   <= owner_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
    end
  end

  assign out_valid_o = valid_q;
  assign owner_o     = owner_q;
  assign phase_o     = phase_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;

endmodule

// File: doc/nco_phase_bank.md
# nco_phase_bank

Multi-channel numerically controlled oscillator front end for `sine_pipe`. Holds up to 16 per-channel phase accumulators and frequency tuning words. On each sample tick it sweeps the channels in order, emitting one `(owner, phase)` pair per clock straight into the sine pipeline's `owner`/`phase` inputs. Each channel's accumulator advances by its tuning word once per sweep.

## Interface
- `CHANNELS`, default 8: active channels, legal 1..16; owner codes `0..CHANNELS-1`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  sample strobe; starts a sweep.
- `cfg_we`  in  1  write `cfg_ftw` into channel `cfg_addr`.
- `cfg_off_we`  in  1  write `cfg_ftw` as the phase offset of channel `cfg_addr` (see Configuration).
- `cfg_addr`  in  4  target channel; writes with `cfg_addr >= CHANNELS` are ignored.
- `cfg_ftw`  in  16  tuning word / offset data, unsigned, full circle = 2^16.
- `cfg_sync`  in  1  zero all accumulators, abort any sweep, clear flags.
- `out_valid`  out  1  `owner`/`phase` valid this cycle.
- `owner`  out  4  channel index, drives `sine_pipe.owner`.
- `phase`  out  16  channel phase, drives `sine_pipe.phase`.
- `busy`  out  1  sweep in progress or pending.
- `overrun`  out  1  sticky: a tick was dropped.

## Operation
- Reset values: accumulators, FTWs and offsets all 0; state IDLE; `out_valid` 0, `owner` 0, `phase` 0, `busy` 0, `overrun` 0.
- State IDLE:
  - `tick` → SWEEP with index 0.
- State SWEEP, each cycle:
  - Register `out_valid`=1, `owner`=index, `phase`=acc[index] (pre-increment value).
  - Write acc[index] ← acc[index]+ftw[index] mod 2^16; wrap is silent.
  - Increment index.
  - After index `CHANNELS-1`: if `pending`, clear it and restart at index 0 in the next cycle with no gap; otherwise → IDLE.
- Tick during SWEEP:
  - `pending` clear → set `pending`.
  - `pending` already set → tick dropped, `overrun` set.
  - Tick in the final sweep cycle counts as pending.
- `cfg_we` and the channel's own update in the same cycle: the update uses the old FTW, and the new FTW applies from the next sweep. Writes to other channels apply immediately.
- `cfg_sync` has priority over everything else:
  - Clears all accumulators, `pending` and `overrun`; goes to IDLE; `out_valid` is 0 next cycle.
  - FTWs and offsets are kept.
  - A `tick` in the same cycle is accepted and starts a sweep from zeroed phases.
- Non-valid cycles hold `owner`/`phase` at their last values. Downstream gates on `out_valid` carried alongside `owner`.
- `busy` = (state==SWEEP) | `pending`.

## Timing
- `tick` high in cycle t → `out_valid` high in cycles t+1 .. t+CHANNELS, owners ascending 0..CHANNELS-1.
- Back-to-back sweeps run with zero idle cycles. Minimum tick spacing without overrun is `CHANNELS` cycles.
- Config write in cycle t is visible to any channel update in cycle t+1 or later.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `NCO_PHASE_OFFSET_EN` defined:
  - Per-channel 16-bit offset register, written by `cfg_off_we`.
  - Emitted `phase` = acc[index]+off[index] mod 2^16.
  - The accumulator itself is never offset.
  - `cfg_sync` does not clear offsets.
- Not defined: `cfg_off_we` is ignored, no offset storage is built, and `phase` = acc[index].

## Structure
- Package `nco_pkg` holds:
  - `OWNER_W`=4, `PHASE_W`=16, `MAX_CHANNELS`=16.
  - State enum {IDLE, SWEEP}.
- Sub-module `nco_reg_file` holds the FTW, accumulator and (optional) offset arrays. It has one read index and one accumulator write port plus config write ports, so storage can map to distributed RAM.
- The top level holds the FSM, index counter, `pending`/`overrun` logic and the output registers.

## Test plan
- Reset; ftw[0]=0x0100, ftw[1]=0x4000; tick ×3 at spacing 8 → owner 0 phases 0x0000, 0x0100, 0x0200; owner 1 phases 0x0000, 0x4000, 0x8000.
- ftw[2]=0xC000, 6 sweeps → owner 2 phases 0x0000, 0xC000, 0x8000, 0x4000, 0x0000, 0xC000 (wrap).
- Ticks at cycles 0, 2 and 4 with CHANNELS=8:
  - 16 contiguous valid cycles, `busy` high throughout.
  - Third tick dropped; `overrun`=1 from the cycle after the third tick.
- `cfg_sync` at sweep index 3 → `out_valid` 0 next cycle; `overrun` clears; the next tick emits all phases 0x0000.
- `cfg_we` to channel 1 in the same cycle as channel 1's update → that sweep advances by the old FTW, the next sweep by the new one.
- With `NCO_PHASE_OFFSET_EN`: off[0]=0x4000, ftw[0]=0 → owner 0 phase 0x4000 every sweep. Without the macro → 0x0000.
